// File: rtl/fire_seq_pkg.sv
// -----------------------------------------------------------------------------
// fire_seq_pkg
// Shared definitions for the fire-layer sequencer:
//   - layout of the 29-bit layer configuration word
//   - 3-bit state encoding and the state enum built on it
//   - default configuration table depth
// -----------------------------------------------------------------------------
package fire_seq_pkg;

    localparam int DEF_MAX_LAYERS = 16;

    // Layer word layout
    localparam int CFG_W        = 29;
    localparam int EXP1_EN_BIT  = 0;
    localparam int EXP3_EN_BIT  = 1;
    localparam int EXP1_LIM_LSB = 2;
    localparam int EXP1_LIM_W   = 7;
    localparam int DEPTH_LSB    = 9;
    localparam int DEPTH_W      = 6;
    localparam int DIM_LSB      = 15;
    localparam int DIM_W        = 7;
    localparam int EXP3_LIM_LSB = 22;
    localparam int EXP3_LIM_W   = 7;

    // State encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_NEXT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_START = ST_START,
        S_WAIT  = ST_WAIT,
        S_NEXT  = ST_NEXT,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/fire_layer_cfg_table.sv
// -----------------------------------------------------------------------------
// fire_layer_cfg_table
// Per-layer configuration store with one write port and a registered read.
// The read register doubles as the sequencer's configuration output register:
// it only updates when rd_en_i is high, so the current layer's word stays
// stable between loads.
// Ports:
//   clk_i, rst_i      clock, async active-high reset (clears read register only)
//   wr_en_i           write strobe (already qualified by the caller)
//   wr_addr_i/data_i  write address / layer word
//   rd_en_i           capture r_mem[rd_addr_i] into the read register
//   rd_addr_i         read address
//   rd_data_o         registered layer word
// -----------------------------------------------------------------------------
module fire_layer_cfg_table
    import fire_seq_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_LAYERS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [CFG_W-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [CFG_W-1:0] rd_data_o
);

    logic [CFG_W-1:0] r_mem [DEPTH];
    logic [CFG_W-1:0] r_rd_data;

    // Table contents survive reset so the host does not need to reprogram
    // the layer list after an error recovery.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read, held between loads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_data <= '0;
        end else if (rd_en_i) begin
            r_rd_data <= r_mem[rd_addr_i];
        end
    end

    assign rd_data_o = r_rd_data;

endmodule

// File: rtl/fire_layer_sequencer.sv
// -----------------------------------------------------------------------------
// fire_layer_sequencer
// Walks a programmed list of layers: for each layer it loads the layer word
// onto the configuration outputs, pulses start_o, then waits until every
// enabled expand engine has reported fire_rd_done before moving on.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   cfg_wr_en_i/addr_i/data_i    table write port (ignored while busy)
//   num_layers_i                 layer count, sampled on an accepted run_i
//   run_i, abort_i               run request / cancel
//   exp1_done_i, exp3_done_i     done levels from the read controllers
//   start_o                      one-cycle start pulse per layer
//   exp_*_en_o, *_limit_o,
//   ker_depth_o, layer_dimension_o  current layer configuration
//   layer_idx_o                  current layer index
//   busy_o, done_o               not-idle flag / end-of-list pulse
// -----------------------------------------------------------------------------
module fire_layer_sequencer
    import fire_seq_pkg::*;
#(
    parameter int MAX_LAYERS = DEF_MAX_LAYERS,
    parameter int LAY_AW     = $clog2(MAX_LAYERS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_wr_en_i,
    input  logic [LAY_AW-1:0] cfg_wr_addr_i,
    input  logic [CFG_W-1:0]  cfg_wr_data_i,
    input  logic [LAY_AW:0]   num_layers_i,
    input  logic              run_i,
    input  logic              abort_i,
    input  logic              exp1_done_i,
    input  logic              exp3_done_i,
    output logic              start_o,
    output logic              exp_1x1_en_o,
    output logic              exp_3x3_en_o,
    output logic [6:0]        one_exp1_ker_addr_limit_o,
    output logic [6:0]        one_exp3_ker_addr_limit_o,
    output logic [5:0]        ker_depth_o,
    output logic [6:0]        layer_dimension_o,
    output logic [LAY_AW-1:0] layer_idx_o,
    output logic              busy_o,
    output logic              done_o
);

    state_t              r_state;
    logic [LAY_AW-1:0]   r_idx;
    logic [LAY_AW:0]     r_count;
    logic                r_s1;
    logic                r_s3;
    logic                r_start;
    logic                r_done;
    logic                r_busy;

    logic [CFG_W-1:0]    w_layer_cfg;
    logic                w_wr_en;
    logic                w_load;
    logic                w_layer_done;
    logic                w_last_layer;

    assign w_wr_en = cfg_wr_en_i & ~r_busy;
    // An abort during LOAD must leave the previous configuration in place.
    assign w_load  = (r_state == S_LOAD) & ~abort_i;

    fire_layer_cfg_table #(
        .DEPTH (MAX_LAYERS),
        .AW    (LAY_AW)
    ) u_cfg_table (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (w_wr_en),
        .wr_addr_i (cfg_wr_addr_i),
        .wr_data_i (cfg_wr_data_i),
        .rd_en_i   (w_load),
        .rd_addr_i (r_idx),
        .rd_data_o (w_layer_cfg)
    );

    assign exp_1x1_en_o              = w_layer_cfg[EXP1_EN_BIT];
    assign exp_3x3_en_o              = w_layer_cfg[EXP3_EN_BIT];
    assign one_exp1_ker_addr_limit_o = w_layer_cfg[EXP1_LIM_LSB +: EXP1_LIM_W];
    assign ker_depth_o               = w_layer_cfg[DEPTH_LSB +: DEPTH_W];
    assign layer_dimension_o         = w_layer_cfg[DIM_LSB +: DIM_W];
    assign one_exp3_ker_addr_limit_o = w_layer_cfg[EXP3_LIM_LSB +: EXP3_LIM_W];

    // A disabled engine counts as done; the live input is ORed in so the
    // layer completes in the same cycle the last done is first seen.
    assign w_layer_done = (r_s1 | exp1_done_i | ~exp_1x1_en_o) &
                          (r_s3 | exp3_done_i | ~exp_3x3_en_o);
    assign w_last_layer = ({1'b0, r_idx} == (r_count - (LAY_AW+1)'(1)));

    // Sequencer FSM with registered start/done/busy outputs. Abort wins over
    // every transition and leaves configuration and index untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_count <= '0;
            r_s1    <= 1'b0;
            r_s3    <= 1'b0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            if (abort_i) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (run_i) begin
                            r_busy <= 1'b1;
                            if (num_layers_i != '0) begin
                                r_count <= num_layers_i;
                                r_idx   <= '0;
                                r_state <= S_LOAD;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_LOAD: begin
                        r_s1    <= 1'b0;
                        r_s3    <= 1'b0;
                        r_start <= 1'b1;
                        r_state <= S_START;
                    end
                    S_START: begin
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (w_layer_done) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_s1 <= r_s1 | exp1_done_i;
                            r_s3 <= r_s3 | exp3_done_i;
                        end
                    end
                    S_NEXT: begin
                        if (w_last_layer) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + LAY_AW'(1);
                            r_state <= S_LOAD;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign start_o     = r_start;
    assign done_o      = r_done;
    assign busy_o      = r_busy;
    assign layer_idx_o = r_idx;

endmodule

// File: tb/tb_fire_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fire_layer_sequencer
// Directed scripts for the layer-sequencing scenarios plus a randomized phase.
// A timeline-style reference model predicts the outputs every cycle; the
// directed scripts additionally pin absolute cycle numbers by hand.
// -----------------------------------------------------------------------------
module tb_fire_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfgWrEn = 1'b0;
    logic [3:0]  cfgWrAddr = '0;
    logic [28:0] cfgWrData = '0;
    logic [4:0]  numLayers = '0;
    logic        run = 1'b0;
    logic        abort = 1'b0;
    logic        exp1Done = 1'b0;
    logic        exp3Done = 1'b0;

    logic        startO, en1O, en3O, busyO, doneO;
    logic [6:0]  lim1O, lim3O, dimO;
    logic [5:0]  depthO;
    logic [3:0]  idxO;
    logic [28:0] cfgBus;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    fire_layer_sequencer #(.MAX_LAYERS(16), .LAY_AW(4)) dut (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .cfg_wr_en_i               (cfgWrEn),
        .cfg_wr_addr_i             (cfgWrAddr),
        .cfg_wr_data_i             (cfgWrData),
        .num_layers_i              (numLayers),
        .run_i                     (run),
        .abort_i                   (abort),
        .exp1_done_i               (exp1Done),
        .exp3_done_i               (exp3Done),
        .start_o                   (startO),
        .exp_1x1_en_o              (en1O),
        .exp_3x3_en_o              (en3O),
        .one_exp1_ker_addr_limit_o (lim1O),
        .one_exp3_ker_addr_limit_o (lim3O),
        .ker_depth_o               (depthO),
        .layer_dimension_o         (dimO),
        .layer_idx_o               (idxO),
        .busy_o                    (busyO),
        .done_o                    (doneO)
    );

    assign cfgBus = {lim3O, dimO, depthO, lim1O, en3O, en1O};

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the run as a set of pending timed events (countdowns in clock
    // edges) rather than as explicit controller states.
    logic [28:0] mTable [16];
    logic        eStart = 1'b0, eDone = 1'b0, eBusy = 1'b0;
    logic [3:0]  eIdx = '0;
    logic [28:0] eCfg = '0;
    logic        mWasBusy;
    int  cfgIn = 0, doneIn = 0, idleIn = 0, idxIn = 0, armIn = 0;
    bit  listening = 1'b0, need1 = 1'b0, need3 = 1'b0;
    int  mLayer = 0, mCount = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eStart = 0; eDone = 0; eBusy = 0; eIdx = '0; eCfg = '0;
            cfgIn = 0; doneIn = 0; idleIn = 0; idxIn = 0; armIn = 0;
            listening = 0; need1 = 0; need3 = 0;
        end else begin
            mWasBusy = eBusy;
            eStart = 0;
            eDone  = 0;
            if (cfgWrEn && !mWasBusy) mTable[cfgWrAddr] = cfgWrData;
            if (abort) begin
                if (mWasBusy) begin
                    eBusy = 0;
                    cfgIn = 0; doneIn = 0; idleIn = 0; idxIn = 0; armIn = 0;
                    listening = 0;
                end
            end else if (!mWasBusy) begin
                if (run) begin
                    eBusy = 1;
                    if (numLayers == 0) begin
                        eDone  = 1;
                        idleIn = 1;
                    end else begin
                        mCount = int'(numLayers);
                        mLayer = 0;
                        eIdx   = '0;
                        cfgIn  = 1;
                    end
                end
            end else begin
                if (idleIn > 0) begin idleIn--; if (idleIn == 0) eBusy = 0; end
                if (doneIn > 0) begin doneIn--; if (doneIn == 0) eDone = 1; end
                if (idxIn > 0)  begin idxIn--;  if (idxIn == 0) eIdx = mLayer[3:0]; end
                if (armIn > 0)  begin armIn--;  if (armIn == 0) listening = 1; end
                if (cfgIn > 0) begin
                    cfgIn--;
                    if (cfgIn == 0) begin
                        eCfg   = mTable[mLayer[3:0]];
                        eStart = 1;
                        need1  = eCfg[0];
                        need3  = eCfg[1];
                        armIn  = 2;
                    end
                end
                if (listening) begin
                    if (exp1Done) need1 = 0;
                    if (exp3Done) need3 = 0;
                    if (!need1 && !need3) begin
                        listening = 0;
                        if (mLayer == mCount - 1) begin
                            doneIn = 1;
                            idleIn = 2;
                        end else begin
                            mLayer++;
                            idxIn = 1;
                            cfgIn = 2;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checkEn && !rst) begin
            checkOutput("start", 32'(startO), 32'(eStart));
            checkOutput("done",  32'(doneO),  32'(eDone));
            checkOutput("busy",  32'(busyO),  32'(eBusy));
            checkOutput("idx",   32'(idxO),   32'(eIdx));
            checkOutput("cfg",   32'(cfgBus), 32'(eCfg));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [3:0] addr, input logic [28:0] data,
                                 input logic runReq, input logic [4:0] n, input logic ab,
                                 input logic d1, input logic d3);
        cfgWrEn = wr; cfgWrAddr = addr; cfgWrData = data;
        run = runReq; numLayers = n; abort = ab;
        exp1Done = d1; exp3Done = d3;
        tick();
    endtask

    task automatic clearInputs();
        cfgWrEn = 0; run = 0; abort = 0; exp1Done = 0; exp3Done = 0; numLayers = '0;
    endtask

    function automatic logic [28:0] makeWord(input logic [1:0] en);
        logic [28:0] w;
        w = 29'($urandom);
        w[1:0] = en;
        return w;
    endfunction

    int          scriptD1 [16];
    int          scriptD3 [16];
    int          startCyc [16];
    logic [3:0]  startIdx [16];
    logic [28:0] startCfg [16];
    logic [28:0] layerWord [16];
    int nStarts, nDones, doneCyc, endCyc, abortCyc, resetCyc, wrCyc, preResetIdx;
    logic [3:0]  wrAddr;
    logic [28:0] wrData;

    task automatic clearScript();
        for (int i = 0; i < 16; i++) begin
            scriptD1[i] = -1;
            scriptD3[i] = -1;
        end
        abortCyc = -1; resetCyc = -1; wrCyc = -1;
    endtask

    // Issues run_i in cycle 0 and serves the done inputs at the scripted
    // offsets from each layer's start pulse.
    task automatic runScript(input logic [4:0] n);
        int  cyc;
        int  curStart;
        int  curLayer;
        bit  stopped;
        logic d1, d3, ab, wr;
        nStarts = 0; nDones = 0; doneCyc = -1; endCyc = -1;
        curLayer = -1; curStart = 0; stopped = 0;
        applyStimulus(0, '0, '0, 1, n, 0, 0, 0);
        for (cyc = 1; cyc < 400 && !stopped; cyc++) begin
            if (startO && nStarts < 16) begin
                startCyc[nStarts] = cyc;
                startIdx[nStarts] = idxO;
                startCfg[nStarts] = cfgBus;
                curLayer = nStarts;
                curStart = cyc;
                nStarts++;
            end
            if (doneO) begin
                nDones++;
                doneCyc = cyc;
            end
            if (!busyO) begin
                endCyc = cyc;
                stopped = 1;
            end else if (cyc == resetCyc) begin
                preResetIdx = int'(idxO);
                rst = 1'b1;
                #1;
                checkOutput("resetBusy",  32'(busyO),  32'd0);
                checkOutput("resetStart", 32'(startO), 32'd0);
                checkOutput("resetDone",  32'(doneO),  32'd0);
                checkOutput("resetIdx",   32'(idxO),   32'd0);
                checkOutput("resetCfg",   32'(cfgBus), 32'd0);
                #2;
                rst = 1'b0;
                clearInputs();
                endCyc = cyc;
                stopped = 1;
            end else begin
                d1 = curLayer >= 0 && scriptD1[curLayer] >= 0 && cyc == curStart + scriptD1[curLayer];
                d3 = curLayer >= 0 && scriptD3[curLayer] >= 0 && cyc == curStart + scriptD3[curLayer];
                ab = (cyc == abortCyc);
                wr = (cyc == wrCyc);
                applyStimulus(wr, wrAddr, wrData, 0, '0, ab, d1, d3);
            end
        end
        if (!stopped) checkOutput("scriptTimeout", 32'd1, 32'd0);
        clearInputs();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clearScript();
        tick();
        tick();
        checkEn = 1'b1;
        rst = 1'b0;
        checkOutput("rstBusy", 32'(busyO), 32'd0);
        checkOutput("rstCfg",  32'(cfgBus), 32'd0);
        tick();

        // Three fully enabled layers, both dones pulsed 4 cycles after start.
        for (int i = 0; i < 3; i++) begin
            layerWord[i] = makeWord(2'b11);
            applyStimulus(1, 4'(i), layerWord[i], 0, '0, 0, 0, 0);
        end
        clearScript();
        for (int i = 0; i < 3; i++) begin scriptD1[i] = 4; scriptD3[i] = 4; end
        runScript(5'd3);
        checkOutput("A_starts", 32'(nStarts), 32'd3);
        checkOutput("A_dones",  32'(nDones),  32'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("A_idx", 32'(startIdx[i]), 32'(i));
            checkOutput("A_cfg", 32'(startCfg[i]), 32'(layerWord[i]));
        end
        checkOutput("A_start0", 32'(startCyc[0]), 32'd2);
        checkOutput("A_start1", 32'(startCyc[1]), 32'd9);
        checkOutput("A_doneCyc", 32'(doneCyc), 32'd22);
        checkOutput("A_endCyc", 32'(endCyc), 32'd23);

        // exp1-only layer, then a sticky exp1 pulse 10 cycles early, then a
        // layer with both engines disabled.
        layerWord[0] = makeWord(2'b01);
        layerWord[1] = makeWord(2'b11);
        layerWord[2] = makeWord(2'b00);
        for (int i = 0; i < 3; i++) applyStimulus(1, 4'(i), layerWord[i], 0, '0, 0, 0, 0);
        clearScript();
        scriptD1[0] = 3;
        scriptD1[1] = 2; scriptD3[1] = 12;
        runScript(5'd3);
        checkOutput("B_start1", 32'(startCyc[1]), 32'd8);
        checkOutput("B_start2", 32'(startCyc[2]), 32'd23);
        checkOutput("B_doneCyc", 32'(doneCyc), 32'd26);
        checkOutput("B_dones", 32'(nDones), 32'd1);

        // Zero layers.
        clearScript();
        runScript(5'd0);
        checkOutput("C_doneCyc", 32'(doneCyc), 32'd1);
        checkOutput("C_starts", 32'(nStarts), 32'd0);
        checkOutput("C_endCyc", 32'(endCyc), 32'd2);

        // Full table of disabled layers.
        for (int i = 0; i < 16; i++) begin
            layerWord[i] = makeWord(2'b00);
            applyStimulus(1, 4'(i), layerWord[i], 0, '0, 0, 0, 0);
        end
        clearScript();
        runScript(5'd16);
        checkOutput("D_starts", 32'(nStarts), 32'd16);
        checkOutput("D_idx15", 32'(startIdx[15]), 32'd15);
        checkOutput("D_start15", 32'(startCyc[15]), 32'd62);
        checkOutput("D_doneCyc", 32'(doneCyc), 32'd65);
        checkOutput("D_dones", 32'(nDones), 32'd1);

        // Abort in the WAIT of layer 1, then a fresh run.
        layerWord[0] = makeWord(2'b11);
        layerWord[1] = makeWord(2'b11);
        for (int i = 0; i < 2; i++) applyStimulus(1, 4'(i), layerWord[i], 0, '0, 0, 0, 0);
        clearScript();
        scriptD1[0] = 2; scriptD3[0] = 2;
        abortCyc = 9;
        runScript(5'd2);
        checkOutput("E_endCyc", 32'(endCyc), 32'd10);
        checkOutput("E_dones", 32'(nDones), 32'd0);
        checkOutput("E_starts", 32'(nStarts), 32'd2);
        clearScript();
        scriptD1[0] = 2; scriptD3[0] = 2; scriptD1[1] = 2; scriptD3[1] = 2;
        runScript(5'd2);
        checkOutput("E_rerunIdx0", 32'(startIdx[0]), 32'd0);
        checkOutput("E_rerunStart0", 32'(startCyc[0]), 32'd2);
        checkOutput("E_rerunDones", 32'(nDones), 32'd1);

        // Write while busy, then reset in the WAIT of layer 1.
        clearScript();
        scriptD1[0] = 2; scriptD3[0] = 2;
        wrCyc = 9; wrAddr = 4'd1; wrData = ~layerWord[1];
        resetCyc = 11;
        runScript(5'd2);
        checkOutput("F_preResetIdx", 32'(preResetIdx), 32'd1);
        tick();
        clearScript();
        scriptD1[0] = 2; scriptD3[0] = 2; scriptD1[1] = 2; scriptD3[1] = 2;
        runScript(5'd2);
        checkOutput("F_cfg1Kept", 32'(startCfg[1]), 32'(layerWord[1]));
        checkOutput("F_starts", 32'(nStarts), 32'd2);

        // Randomized phase.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom_range(0, 3) == 0), 4'($urandom), 29'($urandom),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 16)) : 5'($urandom_range(0, 4)),
                          ($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
        end
        clearInputs();
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
